gf163_digit_serial_mult: RTL



---
 rtl/gf163_pkg.sv | 21 ++
 rtl/gf2_digit_mult.sv | 26 ++
 rtl/gf163_digit_serial_mult.sv | 94 +++++++++
 3 files changed

// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) datapath: field sizes, field polynomial,
// multiplier state type and digit-count helper.
package gf163_pkg;

    localparam int unsigned M      = 163;
    localparam int unsigned PROD_W = 2 * M - 1;

    // x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M:0] FIELD_POLY = {1'b1, 155'd0, 8'hC9};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned num_digits(input int unsigned m, input int unsigned d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2_digit_mult.sv
// Combinational M x DIGIT carry-less partial product: XOR of a shifted by each
// set bit of the digit.
module gf2_digit_mult #(
    parameter int unsigned M     = 163,
    parameter int unsigned DIGIT = 8
) (
    input  logic [M-1:0]       a,
    input  logic [DIGIT-1:0]   d,
    output logic [M+DIGIT-2:0] pp
);

    localparam int unsigned PP_W = M + DIGIT - 1;

    logic [PP_W-1:0] a_ext;

    always_comb begin
        a_ext = PP_W'(a);
        pp    = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (d[i]) begin
                pp = pp ^ (a_ext << i);
            end
        end
    end

endmodule

// File: rtl/gf163_digit_serial_mult.sv
// Digit-serial carry-less multiplier: consumes DIGIT bits of b per cycle, MSB
// first, and presents the unreduced 2M-1 bit product with a done pulse.
module gf163_digit_serial_mult
    import gf163_pkg::*;
#(
    parameter int unsigned M     = 163,
    parameter int unsigned DIGIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    output logic [2*M-2:0] p,
    output logic           busy,
    output logic           done
);

    localparam int unsigned NUM_DIGITS = num_digits(M, DIGIT);
    localparam int unsigned BPAD_W     = NUM_DIGITS * DIGIT;
    localparam int unsigned PW         = 2 * M - 1;
    localparam int unsigned PP_W       = M + DIGIT - 1;
    localparam int unsigned CNT_W      = $clog2(NUM_DIGITS);

    state_t            state;
    logic [M-1:0]      a_reg;
    logic [BPAD_W-1:0] b_reg;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_next;
    logic [CNT_W-1:0]  cnt;
    logic [DIGIT-1:0]  b_digit;
    logic [PP_W-1:0]   pp;

    // b is shifted left each RUN cycle, so the current digit is always at the top
    assign b_digit = b_reg[BPAD_W-1 -: DIGIT];

    gf2_digit_mult #(
        .M     (M),
        .DIGIT (DIGIT)
    ) u_digit_mult (
        .a  (a_reg),
        .d  (b_digit),
        .pp (pp)
    );

    always_comb begin
        acc_next = (acc << DIGIT) ^ PW'(pp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= BPAD_W'(b);
                        acc   <= '0;
                        cnt   <= CNT_W'(NUM_DIGITS - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_reg << DIGIT;
                    if (cnt == '0) begin
                        p     <= acc_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
